// File: rtl/xadc_avg_filter_if.sv
// Sample/average stream bundle between the XADC DRP reader and the averaging filter.
interface xadc_avg_filter_if;
    logic        smp_valid;
    logic [4:0]  smp_channel;
    logic [15:0] smp_data;
    logic        avg_valid;
    logic [2:0]  avg_slot;
    logic [15:0] avg_data;

    modport master (
        output smp_valid, smp_channel, smp_data,
        input  avg_valid, avg_slot, avg_data
    );

    modport slave (
        input  smp_valid, smp_channel, smp_data,
        output avg_valid, avg_slot, avg_data
    );
endinterface

// File: rtl/xadc_avg_filter.sv
// Per-channel boxcar decimator for six XADC channels: 2**LOG2_N samples in, one average out.
// Optional sticky over-threshold alarms are built when XADC_AVG_ALARM_EN is defined.
module xadc_avg_filter #(
    parameter int unsigned LOG2_N = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    xadc_avg_filter_if.slave   bus,
    input  logic               flush,
    input  logic [15:0]        thr_hi,
    input  logic               alarm_clr,
    output logic [5:0]         alarm
);
    localparam int unsigned AW = 12 + LOG2_N;
    // LOG2_N = 0 keeps a 1-bit counter pinned at 0 so every sample finishes.
    localparam int unsigned CW = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam logic [CW-1:0] CNT_LAST = CW'((2 ** LOG2_N) - 1);

    logic [AW-1:0] r_acc [6];
    logic [CW-1:0] r_cnt [6];
    logic          r_avg_valid;
    logic [2:0]    r_avg_slot;
    logic [15:0]   r_avg_data;

    logic          w_hit;
    logic [2:0]    w_slot;
    logic [11:0]   w_s;
    logic [AW-1:0] w_sum;
    logic          w_take;
    logic          w_last;
    logic          w_unused_lsb;

    always_comb begin
        w_hit  = 1'b1;
        w_slot = '0;
        case (bus.smp_channel)
            5'b10110: w_slot = 3'd0;
            5'b11110: w_slot = 3'd1;
            5'b10111: w_slot = 3'd2;
            5'b11111: w_slot = 3'd3;
            5'b00000: w_slot = 3'd4;
            5'b00001: w_slot = 3'd5;
            default:  w_hit  = 1'b0;
        endcase
    end

    assign w_s          = bus.smp_data[15:4];
    assign w_unused_lsb = ^bus.smp_data[3:0];
    assign w_take       = bus.smp_valid && w_hit && !flush;
    assign w_last       = (r_cnt[w_slot] == CNT_LAST);
    assign w_sum        = r_acc[w_slot] + AW'(w_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 6; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_avg_valid <= 1'b0;
            r_avg_slot  <= '0;
            r_avg_data  <= '0;
        end else begin
            r_avg_valid <= w_take && w_last;
            if (flush) begin
                for (int unsigned i = 0; i < 6; i++) begin
                    r_acc[i] <= '0;
                    r_cnt[i] <= '0;
                end
            end else if (w_take) begin
                if (w_last) begin
                    r_acc[w_slot] <= '0;
                    r_cnt[w_slot] <= '0;
                    r_avg_slot    <= w_slot;
                    r_avg_data    <= {w_sum[LOG2_N +: 12], 4'h0};
                end else begin
                    r_acc[w_slot] <= w_sum;
                    r_cnt[w_slot] <= r_cnt[w_slot] + CW'(1);
                end
            end
        end
    end

    assign bus.avg_valid = r_avg_valid;
    assign bus.avg_slot  = r_avg_slot;
    assign bus.avg_data  = r_avg_data;

`ifdef XADC_AVG_ALARM_EN
    logic [5:0] r_alarm;
    logic [5:0] w_set;

    always_comb begin
        w_set = '0;
        if (r_avg_valid && (r_avg_data > thr_hi))
            w_set[r_avg_slot] = 1'b1;
    end

    // A set in the same cycle as alarm_clr survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_alarm <= '0;
        else
            r_alarm <= (alarm_clr ? 6'b0 : r_alarm) | w_set;
    end

    assign alarm = r_alarm;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{thr_hi, alarm_clr};
    assign alarm          = '0;
`endif
endmodule

// File: tb/tb_xadc_avg_filter.sv
// Scoreboard bench for xadc_avg_filter with LOG2_N=2; alarm checks follow XADC_AVG_ALARM_EN.
module tb_xadc_avg_filter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] thr_hi = 16'h8000;
    logic        alarm_clr = 1'b0;
    logic [5:0]  alarm;

    xadc_avg_filter_if bus ();

    xadc_avg_filter #(.LOG2_N(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .flush     (flush),
        .thr_hi    (thr_hi),
        .alarm_clr (alarm_clr),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [18:0] exp_q [$];

    localparam logic [4:0] CH0 = 5'b10110, CH1 = 5'b11110, CH2 = 5'b10111,
                           CH3 = 5'b11111, CH4 = 5'b00000, CH5 = 5'b00001,
                           CHU = 5'b00010;
`ifdef XADC_AVG_ALARM_EN
    localparam bit ALARM_BUILT = 1'b1;
`else
    localparam bit ALARM_BUILT = 1'b0;
`endif

    // Monitor: every emit must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (reset_n && bus.avg_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_emit: got slot=%0d data=%h, required none", bus.avg_slot, bus.avg_data);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({bus.avg_slot, bus.avg_data} !== e) begin
                    n_err++;
                    $display("FAIL emit: got slot=%0d data=%h, required slot=%0d data=%h",
                             bus.avg_slot, bus.avg_data, e[18:16], e[15:0]);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [4:0] ch, input logic [15:0] d,
                         input logic fl, input logic clr);
        @(posedge clk);
        #1;
        bus.smp_valid   = v;
        bus.smp_channel = ch;
        bus.smp_data    = d;
        flush           = fl;
        alarm_clr       = clr;
    endtask

    task automatic smp(input logic [4:0] ch, input logic [15:0] d);
        drive(1'b1, ch, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic expect_emit(input logic [2:0] slot, input logic [15:0] d);
        exp_q.push_back({slot, d});
    endtask

    task automatic check_alarm(input string name, input logic [5:0] req);
        @(negedge clk);
        n_vec++;
        if (alarm !== req) begin
            n_err++;
            $display("FAIL %s: got alarm=%b, required %b", name, alarm, req);
        end
    endtask

    initial begin
        bus.smp_valid   = 1'b0;
        bus.smp_channel = CH0;
        bus.smp_data    = 16'hFFF0;

        // Reset held while samples stream in: nothing may come out.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 bus.smp_valid = ~bus.smp_valid;
            @(negedge clk);
            n_vec++;
            if (bus.avg_valid !== 1'b0 || bus.avg_data !== 16'h0 || alarm !== 6'h0) begin
                n_err++;
                $display("FAIL reset: got valid=%b data=%h alarm=%b, required 0 0000 000000",
                         bus.avg_valid, bus.avg_data, alarm);
            end
        end
        drive(1'b0, CH0, 16'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        idle(2);

        // Basic average: 0x100+0x200+0x300+0x400 = 0xA00, /4 = 0x280.
        smp(CH0, 16'h1000); smp(CH0, 16'h2000); smp(CH0, 16'h3000);
        smp(CH0, 16'h4000); expect_emit(3'd0, 16'h2800);
        idle(3);

        // Interleaved slots plus an unmapped channel.
        for (int i = 0; i < 4; i++) begin
            smp(CH0, 16'h8000); if (i == 3) expect_emit(3'd0, 16'h8000);
            smp(CH4, 16'h0100); if (i == 3) expect_emit(3'd4, 16'h0100);
            smp(CHU, 16'hFFF0);
        end
        idle(3);

        // Flush discards partials; a sample alongside flush is dropped.
        smp(CH1, 16'h1230); smp(CH1, 16'h1230);
        drive(1'b0, CH1, 16'h0, 1'b1, 1'b0);
        drive(1'b1, CH1, 16'hFFF0, 1'b1, 1'b0);
        smp(CH1, 16'h4440); smp(CH1, 16'h4440); smp(CH1, 16'h4440);
        smp(CH1, 16'h4440); expect_emit(3'd1, 16'h4440);
        idle(3);

        // Flush right after a finishing sample does not cancel that emit.
        smp(CH2, 16'h1000); smp(CH2, 16'h1000); smp(CH2, 16'h1000);
        smp(CH2, 16'h1000); expect_emit(3'd2, 16'h1000);
        drive(1'b0, CH2, 16'h0, 1'b1, 1'b0);
        idle(3);

        // Full-scale back to back: no overflow, counter wraps.
        for (int i = 0; i < 8; i++) begin
            smp(CH3, 16'hFFF0);
            if (i == 3 || i == 7) expect_emit(3'd3, 16'hFFF0);
        end
        idle(3);

        // Reset mid-accumulation: partial sum lost, next four form a clean average.
        smp(CH0, 16'hFFF0); smp(CH0, 16'hFFF0);
        @(posedge clk); #1 reset_n = 1'b0;
        drive(1'b0, CH0, 16'h0, 1'b0, 1'b0);
        reset_n = 1'b1;
        smp(CH0, 16'h4000); smp(CH0, 16'h4000); smp(CH0, 16'h4000);
        smp(CH0, 16'h4000); expect_emit(3'd0, 16'h4000);
        idle(3);

        // Alarms: slot 4 over threshold, slot 5 under it.
        thr_hi = 16'h8000;
        for (int i = 0; i < 4; i++) smp(CH4, 16'h9000);
        expect_emit(3'd4, 16'h9000);
        for (int i = 0; i < 4; i++) smp(CH5, 16'h7000);
        expect_emit(3'd5, 16'h7000);
        idle(3);
        check_alarm("alarm_set", ALARM_BUILT ? 6'b010000 : 6'b000000);
        idle(4);
        check_alarm("alarm_sticky", ALARM_BUILT ? 6'b010000 : 6'b000000);
        drive(1'b0, CH0, 16'h0, 1'b0, 1'b1);
        idle(1);
        check_alarm("alarm_clr", 6'b000000);
        for (int i = 0; i < 4; i++) smp(CH4, 16'h9000);
        expect_emit(3'd4, 16'h9000);
        drive(1'b0, CH0, 16'h0, 1'b0, 1'b1);
        idle(2);
        check_alarm("alarm_set_beats_clr", ALARM_BUILT ? 6'b010000 : 6'b000000);

        // Drain: every expected emit must have appeared within the budget.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d emits outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
